// File: rtl/approx_mult_pkg.sv
// Shared mode encodings and FSM state type for the approximate/exact multiplier.
package approx_mult_pkg;

    localparam logic [1:0] MODE_Y81     = 2'd0;
    localparam logic [1:0] MODE_LEAD1   = 2'd1;
    localparam logic [1:0] MODE_EXACT_U = 2'd2;
    localparam logic [1:0] MODE_EXACT_S = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lead_one_det.sv
// Leading-one detector: index of the most significant set bit, plus an all-zero flag.
module lead_one_det #(
    parameter int W = 32
) (
    input  logic [W-1:0]         i_val,
    output logic [$clog2(W)-1:0] o_idx,
    output logic                 o_zero
);

    localparam int IW = $clog2(W);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < W; i++) begin
            if (i_val[i]) o_idx = IW'(i);
        end
        o_zero = ~|i_val;
    end

endmodule

// File: rtl/approx_mult_seq.sv
// Sequential multiplier: single-cycle approximations (Y81, leading-one) and
// W-cycle exact shift-add in unsigned or sign-magnitude signed form.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | shift-add iterations, one multiplier bit per cycle
// DONE  | result held on y until out_ready
module approx_mult_seq
    import approx_mult_pkg::*;
#(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   y
);

    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2*W-1:0]   r_mcand;
    logic [2*W-1:0]   r_acc;
    logic [2*W-1:0]   r_y;
    logic [W-1:0]     r_mplier;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;

    logic             w_accept;
    logic             w_a_zero;
    logic             w_b_zero;
    logic [IW-1:0]    w_a_idx_unused;
    logic [IW-1:0]    w_b_idx;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic             w_quick;
    logic [2*W-1:0]   w_quick_y;
    logic [2*W-1:0]   w_sum;
    logic             w_last;

    lead_one_det #(.W(W)) u_lod_a (
        .i_val  (a),
        .o_idx  (w_a_idx_unused),
        .o_zero (w_a_zero)
    );

    lead_one_det #(.W(W)) u_lod_b (
        .i_val  (b),
        .o_idx  (w_b_idx),
        .o_zero (w_b_zero)
    );

    assign w_accept = in_valid && (r_state == IDLE);

    // Magnitudes for signed mode; negating -2^(W-1) yields 2^(W-1) as unsigned, which is exact.
    assign w_a_neg = (mode == MODE_EXACT_S) && a[W-1];
    assign w_b_neg = (mode == MODE_EXACT_S) && b[W-1];
    assign w_a_mag = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag = w_b_neg ? (~b + 1'b1) : b;

    assign w_quick = w_a_zero || w_b_zero || (mode == MODE_Y81) || (mode == MODE_LEAD1);

    always_comb begin
        w_quick_y = '0;
        if (!(w_a_zero || w_b_zero)) begin
            if (mode == MODE_Y81) begin
                w_quick_y = (b == W'(1)) ? {{W{1'b0}}, a} : ({{W{1'b0}}, a} << 1);
            end else if (mode == MODE_LEAD1) begin
                w_quick_y = {{W{1'b0}}, a} << w_b_idx;
            end
        end
    end

    assign w_sum  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last = (r_cnt == CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_quick ? DONE : CALC;
            CALC: if (w_last)   w_state_nxt = DONE;
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_y      <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_quick) begin
                            r_y <= w_quick_y;
                        end else begin
                            r_mcand  <= {{W{1'b0}}, w_a_mag};
                            r_mplier <= w_b_mag;
                            r_acc    <= '0;
                            r_cnt    <= CW'(W);
                            r_neg    <= w_a_neg ^ w_b_neg;
                        end
                    end
                end
                CALC: begin
                    r_acc    <= w_sum;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_y <= r_neg ? (~w_sum + 1'b1) : w_sum;
                    end
                end
                DONE: begin
                    // y reads zero whenever out_valid is low.
                    if (out_ready) r_y <= '0;
                end
                default: r_y <= '0;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign y         = r_y;

endmodule

// File: doc/approx_mult_seq.md
APPROX_MULT_SEQ -- requirements
Module: approx_mult_seq

Interface
REQ-001 The block SHALL have parameter W, default 32, giving operand width (legal range 4..64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands and mode presented.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port mode, input, 2 bits: 0 = Y81 approx, 1 = leading-one approx, 2 = exact unsigned, 3 = exact signed.
REQ-007 The block SHALL have port a, input, W bits: multiplicand.
REQ-008 The block SHALL have port b, input, W bits: multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: y holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: consumer accepts y.
REQ-011 The block SHALL have port y, output, 2W bits: product.

Function
REQ-012 The block SHALL accept operands on a cycle where in_valid and in_ready are both 1; a, b and mode SHALL be registered then, and later input changes SHALL be ignored.
REQ-013 The block SHALL use FSM states IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 In every mode, if a == 0 or b == 0 the block SHALL go IDLE->DONE with y = 0.
REQ-015 In mode 0 the block SHALL go IDLE->DONE with y = zero-extended a when b == 1, else y = zero-extended a shifted left by 1.
REQ-016 In mode 1 the block SHALL go IDLE->DONE with y = zero-extended a shifted left by p, where p = bit index of the most significant 1 of b (0..W-1).
REQ-017 For modes 0 and 1, and for zero operands, out_valid SHALL rise the cycle after acceptance (latency 1).
REQ-018 In mode 2 the block SHALL go IDLE->CALC and run W iterations of unsigned shift-add, one bit of b per cycle, LSB first; CALC->DONE after the W-th iteration; out_valid SHALL rise W+1 cycles after acceptance.
REQ-019 Mode 3 SHALL take magnitudes of a and b (two's complement) at acceptance, run the mode-2 datapath, and negate the 2W-bit result if a[W-1] xor b[W-1]; latency SHALL equal mode 2; -2^(W-1) operands SHALL be handled exactly.
REQ-020 All arithmetic SHALL be 2W bits wide with no overflow; the exact modes SHALL produce the mathematically exact product.
REQ-021 In DONE, y SHALL stay stable while out_ready is 0; DONE->IDLE SHALL occur on the cycle out_ready is 1.
REQ-022 No new acceptance SHALL occur in the same cycle as an output handshake; the earliest next acceptance SHALL be the following cycle.
REQ-023 y SHALL be 0 whenever out_valid is 0.

Reset
REQ-024 While rst_n is 0 at a clock edge, the block SHALL return to IDLE and clear the iteration counter, accumulator and y, with in_ready = 1 and out_valid = 0 on the next cycle.
REQ-025 Reset during CALC or DONE SHALL abort the operation with no partial result emitted.

Structure
REQ-026 Package approx_mult_pkg SHALL hold the mode encoding constants (MODE_Y81, MODE_LEAD1, MODE_EXACT_U, MODE_EXACT_S) and the state enum.
REQ-027 Sub-module lead_one_det (parameter W; input W bits; outputs index of the most significant 1 plus a zero flag) SHALL be instantiated for mode 1 and for zero detection.
REQ-028 The iteration counter SHALL be ceil(log2(W+1)) bits wide.

Verification (W=32)
REQ-029 Mode 0, a=7, b=1 -> y=7, out_valid the cycle after acceptance; a=7, b=9 -> y=14.
REQ-030 Mode 1, a=3, b=0x0000_00A0 -> y=3<<7=384; a=0xFFFF_FFFF, b=0x8000_0000 -> y=0x7FFF_FFFF_8000_0000.
REQ-031 Mode 2, a=b=0xFFFF_FFFF -> y=0xFFFF_FFFE_0000_0001, out_valid exactly 33 cycles after acceptance; a=0 -> y=0 at latency 1.
REQ-032 Mode 3, a=-3, b=5 -> y=-15 (0xFFFF_FFFF_FFFF_FFF1); a=b=0x8000_0000 -> y=0x4000_0000_0000_0000.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> y and out_valid stable and in_ready=0; release -> IDLE next cycle.
REQ-034 Assert rst_n=0 at CALC cycle 10 -> next cycle in_ready=1, out_valid=0, y=0; a fresh mode-0 operation then completes correctly.
